// File: rtl/axil_csr_if.sv
// AXI4-Lite slave bus bundle for axil_csr_regs; the master modport is the
// bus-initiator view, the slave modport is what the register block uses.
interface axil_csr_if;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_csr_regs.sv
// AXI4-Lite CSR block: CTRL, STATUS, SCRATCH, ID and sticky EVENT registers.
// Define AXIL_CSR_WSTRB_EN to honour WSTRB byte lanes on writable registers.
module axil_csr_regs #(
    parameter logic [31:0] ID_VALUE = 32'h5A10_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    axil_csr_if.slave   bus,
    output logic [31:0] ctrl_o,
    input  logic [31:0] status_i,
    input  logic [31:0] event_i
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] IDX_CTRL    = 3'd0;
    localparam logic [2:0] IDX_STATUS  = 3'd1;
    localparam logic [2:0] IDX_SCRATCH = 3'd2;
    localparam logic [2:0] IDX_ID      = 3'd3;
    localparam logic [2:0] IDX_EVENT   = 3'd4;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic [31:0] ctrl_q, scratch_q, event_q;
    logic [31:0] rdata_q, rd_mux, wmask, ev_clr;
    logic [1:0]  bresp_q, rresp_q;
    logic [2:0]  w_idx, r_idx;
    logic        w_hit, r_hit, w_commit, r_capture;
    logic        unused_bits;

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] wr_val,
                                          input logic [31:0] mask);
        return (old_val & ~mask) | (wr_val & mask);
    endfunction

    // Only offsets below 0x14 decode; anything else is an error and touches nothing.
    assign w_idx = bus.AWADDR[4:2];
    assign r_idx = bus.ARADDR[4:2];
    assign w_hit = bus.AWADDR < 32'h14;
    assign r_hit = bus.ARADDR < 32'h14;

`ifdef AXIL_CSR_WSTRB_EN
    assign wmask = {{8{bus.WSTRB[3]}}, {8{bus.WSTRB[2]}},
                    {8{bus.WSTRB[1]}}, {8{bus.WSTRB[0]}}};
`else
    assign wmask = '1;
`endif

    assign unused_bits = ^{bus.AWPROT, bus.ARPROT, bus.WSTRB};

    // Write FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        // NOTE: default assignment first so no branch leaves w_next unassigned and infers a latch.
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (bus.AWVALID && bus.WVALID) w_next = W_ACK;
            W_ACK:   w_next = W_RESP;
            W_RESP:  if (bus.BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        bus.AWREADY = (w_state == W_ACK);
        bus.WREADY  = (w_state == W_ACK);
        bus.BVALID  = (w_state == W_RESP);
    end

    // Read FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (bus.ARVALID) r_next = R_ACK;
            R_ACK:   r_next = R_DATA;
            R_DATA:  if (bus.RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        bus.ARREADY = (r_state == R_ACK);
        bus.RVALID  = (r_state == R_DATA);
    end

    assign w_commit  = (w_state == W_ACK);
    assign r_capture = (r_state == R_ACK);
    assign ev_clr    = (w_commit && w_hit && w_idx == IDX_EVENT) ? (bus.WDATA & wmask) : '0;

    // NOTE: non-blocking assignments so a read captured on the commit edge sees the pre-write value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
            event_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (w_commit && w_hit && w_idx == IDX_CTRL)
                ctrl_q <= merge(ctrl_q, bus.WDATA, wmask);
            if (w_commit && w_hit && w_idx == IDX_SCRATCH)
                scratch_q <= merge(scratch_q, bus.WDATA, wmask);
            // Set wins over a coincident write-1-to-clear.
            event_q <= (event_q & ~ev_clr) | event_i;
            if (w_commit)
                bresp_q <= w_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (r_hit) begin
            unique case (r_idx)
                IDX_CTRL:    rd_mux = ctrl_q;
                IDX_STATUS:  rd_mux = status_i;
                IDX_SCRATCH: rd_mux = scratch_q;
                IDX_ID:      rd_mux = ID_VALUE;
                IDX_EVENT:   rd_mux = event_q;
                default:     rd_mux = '0;
            endcase
        end
    end

    // NOTE: the read-data holding registers are reset too, so RDATA is a known 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (r_capture) begin
            rdata_q <= rd_mux;
            rresp_q <= r_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign bus.BRESP = bresp_q;
    assign bus.RDATA = rdata_q;
    assign bus.RRESP = rresp_q;
    assign ctrl_o    = ctrl_q;
endmodule

// File: doc/axil_csr_regs.md
AXIL_CSR_REGS -- requirements
Module: axil_csr_regs

Interface
REQ-001 The block SHALL have parameter ID_VALUE, default 32'h5A10_0001, meaning the constant returned by the ID register.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have write-address ports AWADDR (input, 32), AWPROT (input, 3, ignored), AWVALID (input, 1) and AWREADY (output, 1).
REQ-005 The block SHALL have write-data ports WDATA (input, 32), WSTRB (input, 4), WVALID (input, 1) and WREADY (output, 1).
REQ-006 The block SHALL have write-response ports BRESP (output, 2), BVALID (output, 1) and BREADY (input, 1).
REQ-007 The block SHALL have read-address ports ARADDR (input, 32), ARPROT (input, 3, ignored), ARVALID (input, 1) and ARREADY (output, 1).
REQ-008 The block SHALL have read-data ports RDATA (output, 32), RRESP (output, 2), RVALID (output, 1) and RREADY (input, 1).
REQ-009 The block SHALL have ports ctrl_o (output, 32, CTRL register value), status_i (input, 32, live status) and event_i (input, 32, single-cycle event pulses).

Function
REQ-010 Register map, decoded from ADDR[4:2] with ADDR[1:0] ignored: 0x00 CTRL RW; 0x04 STATUS RO = status_i; 0x08 SCRATCH RW; 0x0C ID RO = ID_VALUE; 0x10 EVENT sticky, write-1-to-clear.
REQ-011 The write FSM SHALL have states W_IDLE, W_ACK and W_RESP.
REQ-012 In W_IDLE, when AWVALID and WVALID are both high, the FSM SHALL go to W_ACK and assert AWREADY and WREADY together for exactly one cycle; AWVALID alone or WVALID alone SHALL NOT be accepted.
REQ-013 On the W_ACK edge, the write SHALL commit and the FSM SHALL go to W_RESP with BVALID=1 on the following cycle.
REQ-014 BVALID and BRESP SHALL hold until BREADY is sampled high, then the FSM SHALL return to W_IDLE; no new write SHALL be accepted before that.
REQ-015 The read FSM SHALL have states R_IDLE, R_ACK and R_DATA.
REQ-016 In R_IDLE, ARVALID SHALL produce a one-cycle ARREADY pulse on the next cycle (R_ACK), and RDATA SHALL be captured on that handshake edge.
REQ-017 RVALID SHALL go high the cycle after the read handshake, with RDATA and RRESP stable until RREADY is sampled high, after which the FSM SHALL return to R_IDLE.
REQ-018 Read and write FSMs SHALL be independent; a read captured on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-019 Writes to STATUS or ID SHALL be ignored with BRESP=OKAY.
REQ-020 Addresses at or above 0x14 SHALL give BRESP or RRESP = 2'b10 (SLVERR) and RDATA=0, and no register SHALL change.
REQ-021 EVENT bit n SHALL be set by event_i[n]=1 and cleared by a write of 1 to bit n; when set and clear coincide, set SHALL win.

Reset
REQ-022 rst_n low SHALL immediately force CTRL, SCRATCH and EVENT to 0; AWREADY, WREADY, ARREADY, BVALID and RVALID to 0; BRESP, RRESP and RDATA to 0; and both FSMs to idle, including mid-transaction.

Configuration
REQ-023 With AXIL_CSR_WSTRB_EN defined, writes to CTRL, SCRATCH and EVENT SHALL update only the byte lanes whose WSTRB bit is 1; without it, WSTRB SHALL be ignored and all 32 bits written.

Verification
REQ-024 Reset then read 0x0C -> RDATA=32'h5A10_0001, RRESP=0, RVALID one cycle after the ARREADY pulse.
REQ-025 Write 0x08=32'hDEADBEEF, read back -> 32'hDEADBEEF; with AXIL_CSR_WSTRB_EN, WSTRB=4'b0001 writing 32'h00000011 -> 32'hDEADBE11.
REQ-026 Write 0x00=32'h3 -> ctrl_o=32'h3 the cycle after the write handshake; BRESP=OKAY; BVALID held while BREADY is low for 5 cycles.
REQ-027 Pulse event_i[4], then write 0x10=32'h10 on the same cycle as a second event_i[4] pulse -> bit 4 stays set; a second clear -> read 0x10 = 0.
REQ-028 Read 0x20 -> RRESP=2'b10, RDATA=0; write 0x20 -> BRESP=2'b10; assert rst_n low during W_RESP -> BVALID=0 immediately and CTRL=0.
